// File: rtl/vsync_format_tracker.sv
// rtl/vsync_format_tracker.sv - continuous PAL/NTSC tracker measuring VSYNC period with lock, glitch and loss-of-signal handling
module vsync_format_tracker #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int THRESHOLD_US = 18_000,
  parameter int MIN_US       = 10_000,
  parameter int TIMEOUT_US   = 40_000,
  parameter int LOCK_COUNT   = 3,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int CNT_WIDTH    = 23
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 vsync_in,
  output logic                 format_valid,
  output logic                 format_type,
  output logic                 format_change,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid
);

  localparam logic FORMAT_NTSC = 1'b0;
  localparam logic FORMAT_PAL  = 1'b1;

  localparam longint CYC_PER_US = longint'(CLK_FREQ / 1_000_000);
  localparam longint THR_CYC    = CYC_PER_US * THRESHOLD_US;
  localparam longint MIN_CYC    = CYC_PER_US * MIN_US;
  localparam longint TO_CYC     = CYC_PER_US * TIMEOUT_US;

  localparam logic [CNT_WIDTH-1:0] THR_C  = CNT_WIDTH'(THR_CYC);
  localparam logic [CNT_WIDTH-1:0] MIN_C  = CNT_WIDTH'(MIN_CYC);
  localparam logic [CNT_WIDTH-1:0] TO_C   = CNT_WIDTH'(TO_CYC);
  localparam logic [3:0]           LOCK_C = 4'(LOCK_COUNT);

  // The counter must be able to reach the timeout value without wrapping.
  if (TO_CYC >= (longint'(1) << CNT_WIDTH)) begin : g_bad_width
    $error("TO_CYC does not fit in CNT_WIDTH bits");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
    $error("LOCK_COUNT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t               state, state_n;
  logic                 sync1, sync2, prev;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [3:0]           streak, streak_n, streak_upd;
  logic                 cand, cand_n, cand_upd;
  logic                 valid_n, type_n, change_n, pv_n;
  logic [CNT_WIDTH-1:0] per_n;
  logic                 edge_det, accept, sample_cls;

  // Two-stage synchronizer plus previous-value register for edge detection.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= vsync_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det   = VSYNC_POL ? (sync2 & ~prev) : (~sync2 & prev);
  assign accept     = (state != IDLE) && edge_det && (cnt >= MIN_C);
  assign sample_cls = (cnt > THR_C) ? FORMAT_PAL : FORMAT_NTSC;

  // Run-length tracking of consecutive samples of the same class, saturating at the lock count.
  always_comb begin
    cand_upd   = cand;
    streak_upd = streak;
    if (sample_cls == cand) begin
      streak_upd = (streak >= LOCK_C) ? LOCK_C : streak + 4'd1;
    end else begin
      cand_upd   = sample_cls;
      streak_upd = 4'd1;
    end
  end

  // Next-state and output decisions; an accepted edge takes priority over the timeout.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    streak_n = streak;
    cand_n   = cand;
    valid_n  = format_valid;
    type_n   = format_type;
    change_n = 1'b0;
    per_n    = period_out;
    pv_n     = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          cnt_n   = CNT_WIDTH'(1);
          state_n = ACQUIRE;
        end
      end
      ACQUIRE, LOCKED: begin
        if (accept) begin
          cnt_n    = CNT_WIDTH'(1);
          per_n    = cnt;
          pv_n     = 1'b1;
          streak_n = streak_upd;
          cand_n   = cand_upd;
          if (streak_upd == LOCK_C) begin
            if (state == ACQUIRE) begin
              state_n = LOCKED;
              valid_n = 1'b1;
              type_n  = cand_upd;
            end else if (cand_upd != format_type) begin
              type_n   = cand_upd;
              change_n = 1'b1;
            end
          end
        end else if (cnt == TO_C) begin
          state_n  = IDLE;
          cnt_n    = '0;
          streak_n = 4'd0;
          valid_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, measurement and output registers, all updated on the same edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      cnt           <= '0;
      streak        <= 4'd0;
      cand          <= FORMAT_NTSC;
      format_valid  <= 1'b0;
      format_type   <= FORMAT_NTSC;
      format_change <= 1'b0;
      period_out    <= '0;
      period_valid  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      streak        <= streak_n;
      cand          <= cand_n;
      format_valid  <= valid_n;
      format_type   <= type_n;
      format_change <= change_n;
      period_out    <= per_n;
      period_valid  <= pv_n;
    end
  end

endmodule

// File: tb/tb_vsync_format_tracker.sv
// tb/tb_vsync_format_tracker.sv - randomized bench for vsync_format_tracker against an event-level reference model
module tb_vsync_format_tracker;

  localparam int CW   = 10;
  localparam int THR  = 180;
  localparam int MINC = 100;
  localparam int TO   = 400;
  localparam int LOCK = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b1;
  logic fv0, ft0, fc0, pv0, fv1, ft1, fc1, pv1;
  logic [CW-1:0] po0, po1;

  always #5 clk = ~clk;

  vsync_format_tracker #(
    .CLK_FREQ(1_000_000), .THRESHOLD_US(THR), .MIN_US(MINC), .TIMEOUT_US(TO),
    .LOCK_COUNT(LOCK), .VSYNC_POL(1'b0), .CNT_WIDTH(CW)
  ) u_dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .vsync_in(vsync),
    .format_valid(fv0), .format_type(ft0), .format_change(fc0),
    .period_out(po0), .period_valid(pv0)
  );

  vsync_format_tracker #(
    .CLK_FREQ(1_000_000), .THRESHOLD_US(THR), .MIN_US(MINC), .TIMEOUT_US(TO),
    .LOCK_COUNT(LOCK), .VSYNC_POL(1'b1), .CNT_WIDTH(CW)
  ) u_dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .vsync_in(~vsync),
    .format_valid(fv1), .format_type(ft1), .format_change(fc1),
    .period_out(po1), .period_valid(pv1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int low_left = 0;

  // reference model: 0 idle, 1 acquiring, 2 locked; times are drive-cycle indices
  int m_state, m_last, m_streak, m_period;
  bit m_cand, m_valid, m_type;
  logic [2:0]  rec_fmt [4];
  logic [31:0] rec_per [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_last = 0; m_streak = 0; m_period = 0;
    m_cand = 1'b0; m_valid = 1'b0; m_type = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rec_fmt[i] = 3'b000;
      rec_per[i] = 32'd0;
    end
    low_left = 0;
    vsync = 1'b1;
  endtask

  // One cycle: check outputs due now (driven 3 cycles ago), drive vsync, advance the model.
  task automatic tick(input bit fall);
    int  k;
    int  per;
    bit  cls, chg, pv;
    @(negedge clk);
    k = (cyc + 1) & 3;
    chk("fmt_pol0", 32'({fv0, ft0, fc0}), 32'(rec_fmt[k]));
    chk("per_pol0", 32'({pv0, po0}), rec_per[k]);
    chk("fmt_pol1", 32'({fv1, ft1, fc1}), 32'(rec_fmt[k]));
    chk("per_pol1", 32'({pv1, po1}), rec_per[k]);
    if (fall) begin
      vsync = 1'b0;
      low_left = 3;
    end else if (low_left > 0) begin
      low_left--;
    end else begin
      vsync = 1'b1;
    end
    chg = 1'b0;
    pv  = 1'b0;
    if (m_state == 0) begin
      if (fall) begin
        m_state = 1;
        m_last  = cyc;
      end
    end else begin
      per = cyc - m_last;
      if (fall && per >= MINC) begin
        cls = (per > THR);
        m_period = per;
        pv = 1'b1;
        m_last = cyc;
        if (cls == m_cand) m_streak = (m_streak + 1 > LOCK) ? LOCK : m_streak + 1;
        else begin
          m_cand = cls;
          m_streak = 1;
        end
        if (m_streak == LOCK) begin
          if (m_state == 1) begin
            m_state = 2;
            m_valid = 1'b1;
            m_type  = m_cand;
          end else if (m_cand != m_type) begin
            m_type = m_cand;
            chg = 1'b1;
          end
        end
      end else if (per == TO) begin
        m_state  = 0;
        m_valid  = 1'b0;
        m_streak = 0;
      end
    end
    rec_fmt[cyc & 3] = {m_valid, m_type, chg};
    rec_per[cyc & 3] = (pv ? (32'd1 << CW) : 32'd0) | 32'(m_period);
    cyc++;
  endtask

  task automatic wait_edge(input int gap);
    repeat (gap - 1) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_fmt_pol0", 32'({fv0, ft0, fc0}), 32'd0);
    chk("rst_per_pol0", 32'({pv0, po0}), 32'd0);
    chk("rst_fmt_pol1", 32'({fv1, ft1, fc1}), 32'd0);
    chk("rst_per_pol1", 32'({pv1, po1}), 32'd0);
    model_reset();
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
  endtask

  int kind, runlen, p, g;

  initial begin
    model_reset();
    repeat (3) tick(1'b0);
    chk("reset_state", 32'({fv0, ft0, fc0, pv0, po0}), 32'd0);
    rst_n = 1'b1;

    repeat (5) wait_edge(150);
    repeat (5) wait_edge(200);
    repeat (4) wait_edge(THR);
    repeat (4) wait_edge(THR + 1);
    repeat (2) wait_edge(MINC);
    repeat (4) wait_edge(250);
    wait_edge(30);
    wait_edge(220);
    wait_edge(TO);
    repeat (TO + 20) tick(1'b0);
    repeat (5) wait_edge(200);
    repeat (TO + 50) tick(1'b0);
    repeat (2) wait_edge(200);
    do_reset();
    repeat (5) wait_edge(200);

    for (int i = 0; i < 40; i++) begin
      kind   = $urandom_range(0, 9);
      runlen = $urandom_range(1, 6);
      if (kind == 9) begin
        repeat ($urandom_range(TO + 1, TO + 120)) tick(1'b0);
      end else begin
        for (int j = 0; j < runlen; j++) begin
          p = (kind < 4) ? $urandom_range(MINC, THR) : $urandom_range(THR + 1, TO);
          case ($urandom_range(0, 11))
            0: p = MINC;
            1: p = THR;
            2: p = THR + 1;
            3: p = TO;
            default: ;
          endcase
          if ($urandom_range(0, 5) == 0) begin
            g = $urandom_range(6, MINC - 6);
            wait_edge(g);
            wait_edge(p - g);
          end else begin
            wait_edge(p);
          end
        end
      end
    end

    repeat (6) tick(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
